m4_result_packer: RTL

- Downstream stage of the Top datapath: accepts a stream of 16-bit result samples and packs 8 samples per 128-bit word.
- Writes each packed word into the M4 sram_2R1W through that memory's write port (WE / WriteAddress / WriteBus).
- Tracks the write address, flushes a partial final word on `last`, and reports completion and overflow to the controller.

---
 rtl/m4_result_packer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/m4_result_packer.sv
// m4_result_packer: packs 16-bit result samples eight to a 128-bit word
// and writes each completed word into the M4 memory write port. Tracks
// the write address, zero-pads and flushes a partial word on in_last,
// and reports frame completion and DEPTH overflow to the controller.
//
// Handshake: a sample transfers on every rising clock edge where
// in_valid && in_ready are both 1. in_ready depends only on the FSM state,
// never on in_valid. The producer holds in_data/in_last stable while
// in_valid is high and in_ready is low.
module m4_result_packer #(
   parameter int DATA_W    = 16,
   parameter int LANES     = 8,
   parameter int ADDR_W    = 16,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 65536
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  M4_WriteEnable,
   output logic [ADDR_W-1:0]     M4_WriteAddress,
   output logic [DATA_W*LANES-1:0] M4_WriteBus,
   output logic [ADDR_W:0]       words_written,
   output logic                  done,
   output logic                  overflow,
   output logic [1:0]            stateDbg
);

   localparam int WORD_W = DATA_W * LANES;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

   localparam logic [LANE_W-1:0] LastLane  = LANE_W'(LANES - 1);
   localparam logic [LANE_W-1:0] LaneOne   = LANE_W'(1);
   localparam logic [ADDR_W-1:0] BaseAddr  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] AddrOne   = ADDR_W'(1);
   localparam logic [ADDR_W:0]   DepthCnt  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PACK = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              nextState;

   logic [ADDR_W-1:0]   addr;
   logic [LANE_W-1:0]   lane;
   logic [WORD_W-1:0]   buffer;
   logic [WORD_W-1:0]   mergedWord;

   logic                accept;
   logic                commit;
   logic                startEntry;

   // FSM state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode plus the state-derived outputs and handshake terms.
   always_comb begin
      nextState  = state;
      in_ready   = 1'b0;
      done       = 1'b0;
      startEntry = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               nextState  = PACK;
               startEntry = 1'b1;
            end
         end
         PACK: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               nextState = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               nextState  = PACK;
               startEntry = 1'b1;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
      accept = in_valid && in_ready;
      commit = accept && ((lane == LastLane) || in_last);
   end

   // Current buffer with the incoming sample dropped into its lane; lanes
   // above the current one are still zero because the buffer clears on commit.
   always_comb begin
      mergedWord = buffer;
      mergedWord[lane*DATA_W +: DATA_W] = in_data;
   end

   // Datapath: lane packing, commit to M4, address and word tracking.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr            <= '0;
         lane            <= '0;
         buffer          <= '0;
         M4_WriteEnable  <= 1'b0;
         M4_WriteAddress <= '0;
         M4_WriteBus     <= '0;
         words_written   <= '0;
         overflow        <= 1'b0;
      end else begin
         M4_WriteEnable <= 1'b0;
         if (startEntry) begin
            addr          <= BaseAddr;
            lane          <= '0;
            buffer        <= '0;
            words_written <= '0;
            overflow      <= 1'b0;
         end else if (accept) begin
            if (commit) begin
               lane   <= '0;
               buffer <= '0;
               if (words_written == DepthCnt) begin
                  // No room left: drop the word, remember it, hold counters.
                  overflow <= 1'b1;
               end else begin
                  M4_WriteEnable  <= 1'b1;
                  M4_WriteAddress <= addr;
                  M4_WriteBus     <= mergedWord;
                  addr            <= addr + AddrOne;
                  words_written   <= words_written + CountOne;
               end
            end else begin
               buffer <= mergedWord;
               lane   <= lane + LaneOne;
            end
         end
      end
   end

   assign stateDbg = state;

endmodule
